// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard controller for the CPU pipeline. Produces per-buffer flush/stall vectors
//   (bit 0 = IF/ID ... bit NUM_BUF-1 = last buffer before WB) from branch, memory,
//   load-use and alert conditions. Holds multi-cycle load-use stalls and a timed
//   alert drain in a small FSM. One instance per core.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN (adds the two perf counter outputs).
//
// Ports
//   clk              in   clock, all state on rising edge
//   rst              in   synchronous active-high reset
//   alert            in   interrupt/exception alert (level)
//   branch_miss      in   branch mispredict resolved this cycle
//   mem_stall        in   memory not ready, freeze pipeline
//   load_hazard      in   load-use dependency detected in decode
//   branch_call_jump in   taken control transfer in decode
//   flush            out  per-buffer flush
//   stall            out  per-buffer stall (hold contents)
//   busy             out  FSM not idle
//   perf_stall_cyc   out  cycles with any stall bit set   (HAZARD_PERF_CNT_EN)
//   perf_flush_evt   out  cycles with any flush bit set   (HAZARD_PERF_CNT_EN)
module pipeline_hazard_ctrl #(
   parameter int unsigned NUM_BUF        = 4,
   parameter int unsigned BR_RESOLVE     = 3,
   parameter int unsigned LD_STALL_DEPTH = 3,
   parameter int unsigned LD_STALL_CYC   = 1,
   parameter int unsigned ALERT_DRAIN    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alert,
   input  logic               branch_miss,
   input  logic               mem_stall,
   input  logic               load_hazard,
   input  logic               branch_call_jump,
   output logic [NUM_BUF-1:0] flush,
   output logic [NUM_BUF-1:0] stall,
   output logic               busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cyc,
   output logic [31:0]        perf_flush_evt
`endif
);

   localparam int unsigned MaxCyc = (LD_STALL_CYC > ALERT_DRAIN) ? LD_STALL_CYC : ALERT_DRAIN;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   function automatic logic [NUM_BUF-1:0] low_mask(input int unsigned n);
      logic [NUM_BUF-1:0] m;
      for (int unsigned i = 0; i < NUM_BUF; i++) m[i] = (i < n);
      return m;
   endfunction

   // One-hot at n; empty when n is past the last buffer (no bubble slot).
   function automatic logic [NUM_BUF-1:0] bit_mask(input int unsigned n);
      logic [NUM_BUF-1:0] m;
      for (int unsigned i = 0; i < NUM_BUF; i++) m[i] = (i == n);
      return m;
   endfunction

   localparam logic [NUM_BUF-1:0] BrMask   = low_mask(BR_RESOLVE);
   localparam logic [NUM_BUF-1:0] LdMask   = low_mask(LD_STALL_DEPTH);
   localparam logic [NUM_BUF-1:0] LdBubble = bit_mask(LD_STALL_DEPTH);
   localparam logic [NUM_BUF-1:0] Buf0     = bit_mask(0);
   localparam logic [NUM_BUF-1:0] AllMask  = low_mask(NUM_BUF);
   localparam logic [CntW-1:0]    LdLoad   = CntW'(LD_STALL_CYC - 1);
   localparam logic [CntW-1:0]    DrLoad   = CntW'(ALERT_DRAIN - 1);
   localparam logic [CntW-1:0]    CntOne   = CntW'(1);

   typedef enum logic [1:0] {StIdle, StLdStall, StDrain} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [NUM_BUF-1:0] flush_c, stall_c;

   always_comb begin
      flush_c = '0;
      stall_c = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (alert) begin
               flush_c = Buf0;
               if (ALERT_DRAIN > 1) begin
                  state_d = StDrain;
                  cnt_d   = DrLoad;
               end
            end else if (branch_miss) begin
               flush_c = BrMask;
            end else if (mem_stall) begin
               stall_c = AllMask;
            end else if (load_hazard) begin
               stall_c = LdMask;
               flush_c = LdBubble;
               if (LD_STALL_CYC > 1) begin
                  state_d = StLdStall;
                  cnt_d   = LdLoad;
               end
            end else if (branch_call_jump) begin
               flush_c = Buf0;
            end
         end
         StLdStall: begin
            if (alert) begin
               flush_c = Buf0;
               state_d = (ALERT_DRAIN > 1) ? StDrain : StIdle;
               cnt_d   = DrLoad;
            end else if (branch_miss) begin
               flush_c = BrMask;
               state_d = StIdle;
               cnt_d   = '0;
            end else if (mem_stall) begin
               stall_c = AllMask;
            end else begin
               stall_c = LdMask;
               flush_c = LdBubble;
               if (cnt_q <= CntOne) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
         end
         StDrain: begin
            flush_c = Buf0;
            if (alert) begin
               cnt_d = DrLoad;
            end else if (mem_stall && !branch_miss) begin
               // Buffer 0 keeps draining while the rest of the pipe is frozen.
               stall_c = AllMask & ~Buf0;
            end else begin
               if (branch_miss) flush_c = flush_c | BrMask;
               if (cnt_q <= CntOne) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      // Flush takes precedence on any shared bit.
      stall_c = stall_c & ~flush_c;
   end

   always_comb begin
      flush = rst ? '0 : flush_c;
      stall = rst ? '0 : stall_c;
      busy  = !rst && (state_q != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (|stall && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
         if (|flush && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   always_comb begin
      perf_stall_cyc = rst ? '0 : perf_stall_q;
      perf_flush_evt = rst ? '0 : perf_flush_q;
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       alert;
   logic       branch_miss;
   logic       mem_stall;
   logic       load_hazard;
   logic       branch_call_jump;
   logic [3:0] flush;
   logic [3:0] stall;
   logic       busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cyc;
   logic [31:0] perf_flush_evt;
`endif

   pipeline_hazard_ctrl #(
      .NUM_BUF        (4),
      .BR_RESOLVE     (3),
      .LD_STALL_DEPTH (3),
      .LD_STALL_CYC   (3),
      .ALERT_DRAIN    (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .alert            (alert),
      .branch_miss      (branch_miss),
      .mem_stall        (mem_stall),
      .load_hazard      (load_hazard),
      .branch_call_jump (branch_call_jump),
      .flush            (flush),
      .stall            (stall),
      .busy             (busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cyc   (perf_stall_cyc),
      .perf_flush_evt   (perf_flush_evt)
`endif
   );

   typedef struct {
      logic [3:0]  f;
      logic [3:0]  s;
      logic        b;
      logic        pchk;
      logic [31:0] pstall;
      logic [31:0] pflush;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs packed as {rst, alert, branch_miss, mem_stall, load_hazard, branch_call_jump}.
   task automatic drive(input logic [5:0] in, input logic [3:0] ef, input logic [3:0] es,
                        input logic eb, input logic pchk, input logic [31:0] ps,
                        input logic [31:0] pf, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      {rst, alert, branch_miss, mem_stall, load_hazard, branch_call_jump} = in;
      e.f = ef; e.s = es; e.b = eb;
      e.pchk = pchk; e.pstall = ps; e.pflush = pf;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step(input logic [5:0] in, input logic [3:0] ef, input logic [3:0] es,
                       input logic eb, input string nm);
      drive(in, ef, es, eb, 1'b0, 32'd0, 32'd0, nm);
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({flush, stall, busy} !== {e.f, e.s, e.b}) begin
               errors++;
               $display("FAIL %s: got flush=%b stall=%b busy=%b, want flush=%b stall=%b busy=%b",
                        e.name, flush, stall, busy, e.f, e.s, e.b);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e.pchk) begin
               checks++;
               if ({perf_stall_cyc, perf_flush_evt} !== {e.pstall, e.pflush}) begin
                  errors++;
                  $display("FAIL %s_perf: got stall_cyc=%0d flush_evt=%0d, want %0d %0d",
                           e.name, perf_stall_cyc, perf_flush_evt, e.pstall, e.pflush);
               end
            end
`endif
         end
      end
   end

   initial begin
      {rst, alert, branch_miss, mem_stall, load_hazard, branch_call_jump} = 6'b100000;

      // Reset dominates all inputs, then alert wins on release.
      step(6'b111111, 4'b0000, 4'b0000, 1'b0, "rst_all1_a");
      step(6'b111111, 4'b0000, 4'b0000, 1'b0, "rst_all1_b");
      step(6'b011111, 4'b0001, 4'b0000, 1'b0, "release_alert");
      step(6'b000000, 4'b0001, 4'b0000, 1'b1, "drain_tail");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle_quiet");

      // Idle single-source behaviour and priority.
      step(6'b001000, 4'b0111, 4'b0000, 1'b0, "idle_branch_miss");
      step(6'b000100, 4'b0000, 4'b1111, 1'b0, "idle_mem_stall");
      step(6'b000001, 4'b0001, 4'b0000, 1'b0, "idle_bcj");
      step(6'b000101, 4'b0000, 4'b1111, 1'b0, "idle_ms_over_bcj");
      step(6'b001110, 4'b0111, 4'b0000, 1'b0, "idle_bm_over_ms");

      // Three-cycle load-use stall from a one-cycle pulse.
      step(6'b000010, 4'b1000, 4'b0111, 1'b0, "ld_c0");
      step(6'b000000, 4'b1000, 4'b0111, 1'b1, "ld_c1");
      step(6'b000000, 4'b1000, 4'b0111, 1'b1, "ld_c2");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "ld_done");

      // mem_stall inside LD_STALL freezes the count.
      step(6'b000010, 4'b1000, 4'b0111, 1'b0, "ldms_c0");
      step(6'b000100, 4'b0000, 4'b1111, 1'b1, "ldms_ms1");
      step(6'b000100, 4'b0000, 4'b1111, 1'b1, "ldms_ms2");
      step(6'b000000, 4'b1000, 4'b0111, 1'b1, "ldms_r1");
      step(6'b000000, 4'b1000, 4'b0111, 1'b1, "ldms_r2");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "ldms_done");

      // branch_miss aborts LD_STALL.
      step(6'b000010, 4'b1000, 4'b0111, 1'b0, "ldbm_c0");
      step(6'b001000, 4'b0111, 4'b0000, 1'b1, "ldbm_bm");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "ldbm_idle");

      // Alert drain with branch_miss on cycle 2.
      step(6'b010000, 4'b0001, 4'b0000, 1'b0, "dr_alert");
      step(6'b001000, 4'b0111, 4'b0000, 1'b1, "dr_bm");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "dr_idle");

      // mem_stall in drain: upper buffers stall, count frozen.
      step(6'b010000, 4'b0001, 4'b0000, 1'b0, "drms_alert");
      step(6'b000100, 4'b0001, 4'b1110, 1'b1, "drms_ms");
      step(6'b000000, 4'b0001, 4'b0000, 1'b1, "drms_tail");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "drms_idle");

      // Re-alert reloads; load_hazard and bcj ignored in drain.
      step(6'b010000, 4'b0001, 4'b0000, 1'b0, "dra_alert");
      step(6'b010000, 4'b0001, 4'b0000, 1'b1, "dra_reload");
      step(6'b000011, 4'b0001, 4'b0000, 1'b1, "dra_ignore");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "dra_idle");

      // Alert preempts LD_STALL into DRAIN.
      step(6'b000010, 4'b1000, 4'b0111, 1'b0, "lda_c0");
      step(6'b010000, 4'b0001, 4'b0000, 1'b1, "lda_alert");
      step(6'b000000, 4'b0001, 4'b0000, 1'b1, "lda_drain");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "lda_idle");

      // Reset mid-LD_STALL leaves nothing behind.
      step(6'b000010, 4'b1000, 4'b0111, 1'b0, "ldr_c0");
      step(6'b100010, 4'b0000, 4'b0000, 1'b0, "ldr_rst");
      step(6'b000000, 4'b0000, 4'b0000, 1'b0, "ldr_after");

`ifdef HAZARD_PERF_CNT_EN
      drive(6'b100000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0, "perf_rst");
      for (int i = 0; i < 5; i++) step(6'b000100, 4'b0000, 4'b1111, 1'b0, "perf_ms");
      for (int i = 0; i < 2; i++) step(6'b000001, 4'b0001, 4'b0000, 1'b0, "perf_bcj");
      drive(6'b000000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd5, 32'd2, "perf_count");
`endif

      repeat (3) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_queue: got %0d pending, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
